hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32I core. Drives the forwarding mux selects,
//  the control-bubble mux select, per-stage register load enables and flushes. Freezes the pipe

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencer: forwarding selects, bubbles, flushes, memory-stall freeze
// Two-state RUN/STALL control with latched early memory completions and saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             ctrl_sel,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_flush
);

  typedef enum logic {RUN, STALL} state_t;

  state_t state, state_nxt;
  logic   i_done, d_done;
  logic   i_ok, d_ok, mem_ok;
  logic   load_use;
  logic   advance;

  assign i_ok   = ~imem_read | imem_resp | i_done;
  assign d_ok   = ~dmem_req | dmem_resp | d_done;
  assign mem_ok = i_ok & d_ok;

  assign load_use = ex_is_load & ex_regwrite & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 is hardwired zero.
  function automatic logic [1:0] fwd_src(input logic [4:0] src);
    if (src == 5'd0)                          return 2'b00;
    else if (mem_regwrite && (mem_rd == src)) return 2'b10;
    else if (wb_regwrite && (wb_rd == src))   return 2'b01;
    else                                      return 2'b00;
  endfunction

  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    fwd1_sel    = 2'b00;
    fwd2_sel    = 2'b00;
    ctrl_sel    = 1'b1;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      state_nxt   = RUN;
      ctrl_sel    = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      fwd1_sel = fwd_src(ex_rs1);
      fwd2_sel = fwd_src(ex_rs2);
      case (state)
        RUN: begin
          if (mem_ok) advance = 1'b1;
          else        state_nxt = STALL;
        end
        STALL: begin
          if (mem_ok) begin
            advance   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
      if (advance) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        if (ex_br_taken) begin
          load_pc     = 1'b1;
          load_if_id  = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          ctrl_sel = 1'b0;
        end else begin
          load_pc    = 1'b1;
          load_if_id = 1'b1;
        end
      end
    end
  end

  // Completions seen on any frozen cycle are remembered until the pipe finally advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end else begin
        if (imem_resp) i_done <= 1'b1;
        if (dmem_resp) d_done <= 1'b1;
      end
      if (!advance && (perf_stall != '1))
        perf_stall <= perf_stall + CNT_W'(1);
      if (advance && !ex_br_taken && load_use && (perf_bubble != '1))
        perf_bubble <= perf_bubble + CNT_W'(1);
      if (advance && ex_br_taken && (perf_flush != '1))
        perf_flush <= perf_flush + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scenario tasks plus randomized run against a behavioural model
module tb_hazard_ctrl;
  localparam int CNT_W = 5;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, ex_br_taken;
  logic mem_regwrite, wb_regwrite, imem_read, imem_resp, dmem_req, dmem_resp;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic ctrl_sel, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] perf_stall, perf_bubble, perf_flush;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .ctrl_sel(ctrl_sel),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
  );

  // {fwd1, fwd2, ctrl_sel, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
  logic [11:0] got;
  assign got = {fwd1_sel, fwd2_sel, ctrl_sel, load_pc, load_if_id, load_id_ex,
                load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};

  int tests = 0;
  int fails = 0;

  // Model: "a response has already arrived" per port, plus plain integer counters.
  bit m_ih, m_dh;
  int m_stall, m_bub, m_fl;

  function automatic logic [1:0] fwd_of(logic [4:0] s);
    if (s == 5'd0) return 2'b00;
    if (mem_regwrite && mem_rd == s) return 2'b10;
    if (wb_regwrite && wb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_ready();
    return (!imem_read || imem_resp || m_ih) && (!dmem_req || dmem_resp || m_dh);
  endfunction

  function automatic bit m_lu();
    return ex_is_load && ex_regwrite && ex_rd != 5'd0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [11:0] exp_outs();
    logic [3:0] f;
    if (!rst) return 12'b0000_0_00000_11;
    f = {fwd_of(ex_rs1), fwd_of(ex_rs2)};
    if (!m_ready())  return {f, 1'b1, 5'b00000, 2'b00};
    if (ex_br_taken) return {f, 1'b1, 5'b11111, 2'b11};
    if (m_lu())      return {f, 1'b0, 5'b00111, 2'b00};
    return {f, 1'b1, 5'b11111, 2'b00};
  endfunction

  function automatic int sat_inc(int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  // Called at the negedge, then commits to the next posedge (+1) where new inputs get driven.
  task automatic tick();
    if (!rst) begin
      m_ih = 0; m_dh = 0; m_stall = 0; m_bub = 0; m_fl = 0;
    end else if (m_ready()) begin
      m_ih = 0; m_dh = 0;
      if (ex_br_taken) m_fl = sat_inc(m_fl);
      else if (m_lu()) m_bub = sat_inc(m_bub);
    end else begin
      m_stall = sat_inc(m_stall);
      if (imem_resp) m_ih = 1;
      if (dmem_resp) m_dh = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_is_load = 0; ex_br_taken = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    @(negedge clk);
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0; mem_rd = 1; mem_regwrite = 1; ex_rs1 = 1; ex_rs2 = 1; imem_read = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tests++;
    if (got !== 12'b0000_0_00000_11) begin
      fails++; $display("FAIL reset_outs got=%b exp=%b", got, 12'b0000_0_00000_11);
    end
    tests++;
    if (perf_stall !== 0 || perf_bubble !== 0 || perf_flush !== 0) begin
      fails++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", perf_stall, perf_bubble, perf_flush);
    end
    tick();
  endtask

  task automatic test_forwarding();
    do_reset();
    mem_rd = 1; mem_regwrite = 1; ex_rs1 = 1; wb_rd = 1; wb_regwrite = 1;
    @(negedge clk);
    tests++;
    if (fwd1_sel !== 2'b10) begin fails++; $display("FAIL fwd_mem_beats_wb got=%b exp=10", fwd1_sel); end
    tick();
    mem_rd = 3; wb_rd = 2; ex_rs2 = 2; ex_rs1 = 0;
    @(negedge clk);
    tests++;
    if (fwd2_sel !== 2'b01) begin fails++; $display("FAIL fwd_wb got=%b exp=01", fwd2_sel); end
    tests++;
    if (fwd1_sel !== 2'b00) begin fails++; $display("FAIL fwd_none got=%b exp=00", fwd1_sel); end
    tick();
    ex_rs2 = 0; wb_rd = 0; mem_rd = 0;
    @(negedge clk);
    tests++;
    if (fwd2_sel !== 2'b00 || fwd1_sel !== 2'b00) begin
      fails++; $display("FAIL fwd_x0 got=%b%b exp=0000", fwd1_sel, fwd2_sel);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    tests++;
    if (got[8:0] !== 9'b0_00111_00) begin fails++; $display("FAIL load_use_bubble got=%b exp=000111 00", got[8:0]); end
    tick();
    ex_is_load = 0; ex_rd = 0; mem_rd = 5; mem_regwrite = 1; ex_rs1 = 5;
    @(negedge clk);
    tests++;
    if (got !== 12'b10_00_1_11111_00) begin fails++; $display("FAIL load_use_after got=%b exp=%b", got, 12'b10_00_1_11111_00); end
    tests++;
    if (perf_bubble !== 1) begin fails++; $display("FAIL load_use_perf got=%0d exp=1", perf_bubble); end
    tick();
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0; id_use_rs1 = 0; id_rs1 = 7;
    @(negedge clk);
    tests++;
    if (ctrl_sel !== 1'b1) begin fails++; $display("FAIL load_use_unused_src got=%b exp=1", ctrl_sel); end
    tick();
    ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    @(negedge clk);
    tests++;
    if (ctrl_sel !== 1'b1) begin fails++; $display("FAIL load_use_x0 got=%b exp=1", ctrl_sel); end
    tick();
  endtask

  task automatic test_mem_stall();
    do_reset();
    imem_read = 1; dmem_req = 1;
    for (int k = 0; k <= 6; k++) begin
      imem_resp = (k == 2);
      dmem_resp = (k == 6);
      @(negedge clk);
      tests++;
      if (load_pc !== (k == 6) || load_mem_wb !== (k == 6) || ctrl_sel !== 1'b1) begin
        fails++; $display("FAIL mem_stall_t%0d got=%b exp_adv=%0d", k, got, k == 6);
      end
      tick();
    end
    imem_resp = 0; dmem_resp = 0; imem_read = 0; dmem_req = 0;
    @(negedge clk);
    tests++;
    if (perf_stall !== 6) begin fails++; $display("FAIL mem_stall_perf got=%0d exp=6", perf_stall); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_br_taken = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    @(negedge clk);
    tests++;
    if (got[7:0] !== 8'b1_11111_11) begin fails++; $display("FAIL branch_priority got=%b exp=11111111", got[7:0]); end
    tick();
    idle();
    @(negedge clk);
    tests++;
    if (perf_flush !== 1 || perf_bubble !== 0) begin
      fails++; $display("FAIL branch_perf got=%0d/%0d exp=1/0", perf_flush, perf_bubble);
    end
    tick();
  endtask

  task automatic test_reset_stall();
    do_reset();
    imem_read = 1; dmem_req = 1; imem_resp = 1;
    @(negedge clk);
    tick();
    imem_resp = 0;
    @(negedge clk);
    tick();
    rst = 0;
    @(negedge clk);
    tests++;
    if (got !== 12'b0000_0_00000_11) begin fails++; $display("FAIL rst_in_stall got=%b exp=%b", got, 12'b0000_0_00000_11); end
    tick();
    rst = 1; dmem_resp = 1;
    @(negedge clk);
    tests++;
    if (load_pc !== 1'b0 || load_mem_wb !== 1'b0) begin fails++; $display("FAIL rst_stale_flag got=%b exp_loads=00000", got); end
    tick();
    dmem_resp = 0; imem_resp = 1;
    @(negedge clk);
    tests++;
    if (got[7:0] !== 8'b1_11111_00) begin fails++; $display("FAIL rst_then_adv got=%b exp=11111100", got[7:0]); end
    tests++;
    if (perf_stall !== 1) begin fails++; $display("FAIL rst_then_perf got=%0d exp=1", perf_stall); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    imem_read = 1;
    for (int k = 0; k < SAT + 8; k++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    tests++;
    if (perf_stall !== CNT_W'(SAT)) begin fails++; $display("FAIL saturate got=%0d exp=%0d", perf_stall, SAT); end
    tick();
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 59) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_regwrite = 1'($urandom); ex_is_load = 1'($urandom);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      imem_read = ($urandom_range(0, 3) != 0); dmem_req = ($urandom_range(0, 2) == 0);
      imem_resp = imem_read && ($urandom_range(0, 3) == 0);
      dmem_resp = dmem_req && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      tests++;
      if (got !== exp_outs()) begin fails++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", k, got, exp_outs()); end
      tests++;
      if (perf_stall !== CNT_W'(m_stall) || perf_bubble !== CNT_W'(m_bub) || perf_flush !== CNT_W'(m_fl)) begin
        fails++;
        $display("FAIL rand_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k,
                 perf_stall, perf_bubble, perf_flush, m_stall, m_bub, m_fl);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_stall();
    test_branch();
    test_reset_stall();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
